fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, loads the IF/ID register from combinational imem.
// Latency 1 cycle (imem -> if_instr); holds while if_valid && !id_ready; redirect flushes and reloads PC.
module fetch_stage #(
   parameter int PC_W    = 3,
   parameter int INSTR_W = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               if_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic [CNT_W-1:0]   fetch_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t             r_state;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    r_if_pc;
   logic [INSTR_W-1:0] r_if_instr;
   logic [CNT_W-1:0]   r_cnt;

   logic w_valid;
   logic w_load;

   assign w_valid = (r_state == FULL);
   assign w_load  = run && !redirect_valid && (!w_valid || id_ready);

   // Redirect outranks everything: any held word is dropped even if decode is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_pc       <= '0;
         r_if_pc    <= '0;
         r_if_instr <= '0;
         r_cnt      <= '0;
      end else if (redirect_valid) begin
         r_state <= EMPTY;
         r_pc    <= redirect_pc;
      end else if (w_load) begin
         r_state    <= FULL;
         r_if_instr <= imem_instr;
         r_if_pc    <= r_pc;
         r_pc       <= r_pc + PC_ONE;
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end else if (w_valid && id_ready) begin
         r_state <= EMPTY;
      end
   end

   assign imem_pc   = r_pc;
   assign if_valid  = w_valid;
   assign if_instr  = r_if_instr;
   assign if_pc     = r_if_pc;
   assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, scoreboard of loaded words, reset and saturation sequences.
module tb_fetch_stage;

   localparam int PC_W    = 3;
   localparam int INSTR_W = 16;
   localparam int CNT_W   = 8;

   logic               clk;
   logic               rst_n;
   logic               run;
   logic [PC_W-1:0]    imem_pc;
   logic [INSTR_W-1:0] imem_instr;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               if_valid;
   logic               id_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [PC_W-1:0]    if_pc;
   logic [CNT_W-1:0]   fetch_cnt;

   logic [INSTR_W-1:0] mem [0:7];
   logic               imem_en;

   fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .id_ready       (id_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .fetch_cnt      (fetch_cnt)
   );

   // Memory only drives a real word when a load is expected; X otherwise.
   assign imem_instr = imem_en ? mem[imem_pc] : 'x;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } sb_t;

   typedef struct {
      logic               run;
      logic               rdy;
      logic               rv;
      logic [PC_W-1:0]    rpc;
      logic               e_valid;
      logic [PC_W-1:0]    e_pc;
      logic [INSTR_W-1:0] e_instr;
      logic [PC_W-1:0]    e_imem;
      logic [CNT_W-1:0]   e_cnt;
   } vec_t;

   sb_t  sb [$];
   vec_t vecs [16];

   int n_cmp;
   int n_fail;

   logic [PC_W-1:0]  m_pc;
   logic             m_valid;
   logic [CNT_W-1:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = '0;
      m_valid = 1'b0;
      m_cnt   = '0;
      sb.delete();
   endtask

   // One clock cycle with the currently driven inputs; outputs sampled #1 after the edge.
   task automatic step();
      sb_t e;
      imem_en = 1'b0;
      if (m_valid && id_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_if_pc", {29'd0, if_pc}, {29'd0, e.pc});
            chk("sb_if_instr", {16'd0, if_instr}, {16'd0, e.instr});
         end
      end
      if (redirect_valid) begin
         sb.delete();
         m_pc    = redirect_pc;
         m_valid = 1'b0;
      end else if (run && (!m_valid || id_ready)) begin
         imem_en = 1'b1;
         e.pc    = m_pc;
         e.instr = mem[m_pc];
         sb.push_back(e);
         m_pc    = m_pc + 3'd1;
         m_valid = 1'b1;
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else if (m_valid && id_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      imem_en = 1'b0;
      chk("imem_pc", {29'd0, imem_pc}, {29'd0, m_pc});
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("fetch_cnt", {24'd0, fetch_cnt}, {24'd0, m_cnt});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_imem_pc"}, {29'd0, imem_pc}, 32'd0);
      chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
      chk({tag, "_if_instr"}, {16'd0, if_instr}, 32'd0);
      chk({tag, "_if_pc"}, {29'd0, if_pc}, 32'd0);
      chk({tag, "_fetch_cnt"}, {24'd0, fetch_cnt}, 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      imem_en = 1'b0;
      mem[0] = 16'h0500; mem[1] = 16'h0501; mem[2] = 16'h0502; mem[3] = 16'h0503;
      mem[4] = 16'h2504; mem[5] = 16'hEF9F; mem[6] = 16'h0000; mem[7] = 16'h0000;

      //             run rdy rv rpc   valid pc  instr      imem cnt
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 16'h0500, 3'd1, 8'd1};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0501, 3'd2, 8'd2};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0501, 3'd2, 8'd2};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0501, 3'd2, 8'd2};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0501, 3'd2, 8'd2};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0502, 3'd3, 8'd3};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd2, 16'h0502, 3'd5, 8'd3};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 16'hEF9F, 3'd6, 8'd4};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 16'h0000, 3'd7, 8'd5};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd6, 16'h0000, 3'd7, 8'd5};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd6, 16'h0000, 3'd7, 8'd5};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 16'h0000, 3'd0, 8'd6};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 16'h0000, 3'd0, 8'd6};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd7, 16'h0000, 3'd3, 8'd6};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 3'd7, 16'h0000, 3'd4, 8'd6};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 16'h2504, 3'd5, 8'd7};

      // Reset state
      do_reset();
      chk_zero("reset");

      // Table: hold, redirect, run=0 drain, repeated redirect
      for (int i = 0; i < 16; i++) begin
         run            = vecs[i].run;
         id_ready       = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         step();
         chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d_if_pc", i), {29'd0, if_pc}, {29'd0, vecs[i].e_pc});
         chk($sformatf("vec%0d_instr", i), {16'd0, if_instr}, {16'd0, vecs[i].e_instr});
         chk($sformatf("vec%0d_imem_pc", i), {29'd0, imem_pc}, {29'd0, vecs[i].e_imem});
         chk($sformatf("vec%0d_cnt", i), {24'd0, fetch_cnt}, {24'd0, vecs[i].e_cnt});
      end

      // Ten back-to-back fetches from reset, pc wraps 7 -> 0
      do_reset();
      run = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("run10_if_pc", {29'd0, if_pc}, i % 8);
         if (i == 5) chk("run10_instr5", {16'd0, if_instr}, 32'h0000EF9F);
      end
      chk("run10_cnt", {24'd0, fetch_cnt}, 32'd10);

      // Asynchronous reset pulse between edges at if_pc=4
      do_reset();
      run = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("pre_arst_if_pc", {29'd0, if_pc}, 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      #1;
      rst_n = 1'b1;
      model_reset();
      step();
      chk("post_arst_if_pc", {29'd0, if_pc}, 32'd0);
      chk("post_arst_instr", {16'd0, if_instr}, 32'h00000500);

      // Counter saturation over 300 fetches
      do_reset();
      run = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 300; i++) step();
      chk("sat_cnt", {24'd0, fetch_cnt}, 32'd255);
      chk("sat_imem_pc", {29'd0, imem_pc}, 32'd4);
      chk("sat_if_pc", {29'd0, if_pc}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
